// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//   Command controller between the host command port and the key-value entry
//   storage array. Resolves a command in a fixed four-cycle sequence:
//   accept, look up, strobe the target entry, report completion.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a command; NOOPs are consumed here
//   LOOKUP | sample hit/used vectors, register target, hit and full flags
//   ACCESS | drive idx_out and at most one one-cycle strobe
//   DONE   | done pulse with hit/err flags; stats update on exit
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   op_valid_in/op_ready_out   command handshake
//   operation_in               00 NOOP, 01 READ, 10 WRITE, 11 DELETE
//   used_in, hit_in            per-entry occupied / key-match flags
//   idx_out                    one-hot target entry
//   select/write/delete_out    entry strobes (ACCESS only)
//   done_out, hit_out,
//   err_full_out               completion pulse and qualified flags
//   hit_cnt_out, miss_cnt_out  saturating statistics
// ---------------------------------------------------------------------------
module cache_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int STAT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid_in,
  output logic                   op_ready_out,
  input  logic [1:0]             operation_in,
  input  logic [NUM_ENTRIES-1:0] used_in,
  input  logic [NUM_ENTRIES-1:0] hit_in,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   select_out,
  output logic                   write_out,
  output logic                   delete_out,
  output logic                   done_out,
  output logic                   hit_out,
  output logic                   err_full_out,
  output logic [STAT_W-1:0]      hit_cnt_out,
  output logic [STAT_W-1:0]      miss_cnt_out
);

  localparam logic [1:0] OP_NOOP   = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  localparam logic [NUM_ENTRIES-1:0] ENTRY_ONE = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0]      STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [1:0]             op_q;
  logic [NUM_ENTRIES-1:0] tgt_q;
  logic [NUM_ENTRIES-1:0] tgt_d;
  logic                   hit_q;
  logic                   err_q;
  logic                   err_d;
  logic                   hit_any;
  logic [NUM_ENTRIES-1:0] hit_first;
  logic [NUM_ENTRIES-1:0] free_first;
  logic [STAT_W-1:0]      hit_cnt_q;
  logic [STAT_W-1:0]      miss_cnt_q;
  logic                   accept;

  assign accept = (state_q == S_IDLE) && op_valid_in && (operation_in != OP_NOOP);

  // x & -x isolates the lowest set bit, giving the priority pick as one-hot.
  assign hit_any    = |hit_in;
  assign hit_first  = hit_in & (~hit_in + ENTRY_ONE);
  assign free_first = ~used_in & (used_in + ENTRY_ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Target resolution from the storage flags, only registered in LOOKUP.
  always_comb begin
    tgt_d = '0;
    err_d = 1'b0;
    if (hit_any) begin
      tgt_d = hit_first;
    end else if (op_q == OP_WRITE) begin
      if (&used_in) begin
        err_d = 1'b1;
      end else begin
        tgt_d = free_first;
      end
    end
  end

  // Command, lookup result and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOOP;
      tgt_q      <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q <= operation_in;
      end
      if (state_q == S_LOOKUP) begin
        tgt_q <= tgt_d;
        hit_q <= hit_any;
        err_q <= err_d;
      end
      if (state_q == S_DONE) begin
        if (hit_q) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + STAT_ONE;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + STAT_ONE;
        end
      end
    end
  end

  // Outputs decoded from state so reset clears them without a clock edge.
  always_comb begin
    op_ready_out = 1'b0;
    idx_out      = '0;
    select_out   = 1'b0;
    write_out    = 1'b0;
    delete_out   = 1'b0;
    done_out     = 1'b0;
    hit_out      = 1'b0;
    err_full_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready_out = 1'b1;
      end
      S_ACCESS: begin
        idx_out    = tgt_q;
        select_out = (op_q == OP_READ) && hit_q;
        // A write with any target covers both overwrite and allocation.
        write_out  = (op_q == OP_WRITE) && (|tgt_q);
        delete_out = (op_q == OP_DELETE) && hit_q;
      end
      S_DONE: begin
        idx_out      = tgt_q;
        done_out     = 1'b1;
        hit_out      = hit_q;
        err_full_out = err_q;
      end
      default: ;
    endcase
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Parametrised command controller for the key-value cache. It sits between the host command interface and the entry storage array. It accepts NOOP/READ/WRITE/DELETE operations over a valid/ready handshake and resolves key hits from the array's per-entry match vector. It allocates the lowest free entry on a write miss, drives one-hot select/write/delete strobes, and reports completion, hit/miss, full-error and saturating hit/miss statistics.

## Interface
- NUM_ENTRIES, 16, number of cache entries; width of all per-entry vectors (≥2)
- STAT_W, 16, width of each statistics counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- op_valid_in  in  1  command valid
- op_ready_out  out  1  controller can accept a command
- operation_in  in  2  00 NOOP, 01 READ, 10 WRITE, 11 DELETE
- used_in  in  NUM_ENTRIES  entry occupied flags from storage
- hit_in  in  NUM_ENTRIES  per-entry key-match flags from storage
- idx_out  out  NUM_ENTRIES  one-hot target entry
- select_out  out  1  read strobe for entry idx_out
- write_out  out  1  write strobe for entry idx_out
- delete_out  out  1  invalidate strobe for entry idx_out
- done_out  out  1  one-cycle completion pulse
- hit_out  out  1  key found (qualified by done_out)
- err_full_out  out  1  WRITE miss with no free entry (qualified by done_out)
- hit_cnt_out  out  STAT_W  saturating count of completed hits
- miss_cnt_out  out  STAT_W  saturating count of completed misses

## Operation
- Reset value of every output and internal register is 0. The exception is op_ready_out, which is 1 in IDLE after reset. The FSM resets to IDLE.
- States: IDLE, LOOKUP, ACCESS, DONE.
- **IDLE**
  - op_ready_out = 1.
  - On op_valid_in && operation_in != NOOP: latch the operation, go to LOOKUP.
  - A NOOP with valid asserted is consumed. There is no done_out and the FSM stays in IDLE.
- **LOOKUP** (op_ready_out = 0)
  - Sample hit_in and used_in. Compute and register the target index and the hit and err flags.
  - If any hit_in bit is set: target = lowest-index set bit, hit = 1.
  - READ/DELETE miss: no target, hit = 0.
  - WRITE miss: target = lowest-index bit with used_in = 0. If all entries are used: err_full = 1 and no target.
  - Next state: ACCESS.
- **ACCESS**
  - idx_out = registered target.
  - Exactly one strobe fires for one cycle:
    - select_out for a READ hit;
    - write_out for any WRITE with a valid target (hit overwrite or free allocation);
    - delete_out for a DELETE hit.
  - No strobe fires and idx_out = 0 on a READ/DELETE miss or a full error.
  - Next state: DONE.
- **DONE**
  - done_out = 1, hit_out and err_full_out presented, idx_out held.
  - Statistics: a hit increments hit_cnt, a miss increments miss_cnt. A WRITE miss counts as a miss, with or without error.
  - Counters saturate at 2^STAT_W−1 and never wrap.
  - Next state: IDLE.
- hit_out and err_full_out are 0 outside DONE. Strobes are never asserted outside ACCESS.
- used_in and hit_in are ignored in every state except LOOKUP.

## Timing
- Accept edge = rising edge with op_ready_out && op_valid_in.
- Cycle-level schedule after the accept edge:
  - LOOKUP in cycle +1;
  - strobe in cycle +2;
  - done_out in cycle +3;
  - op_ready_out high again in cycle +4.
- Fixed latency, independent of hit/miss. Throughput is one command per 4 cycles.
- Counters update on the edge that leaves DONE, so they are visible in cycle +4.
- op_valid_in is ignored while op_ready_out = 0. No queuing.
- Multiple hit_in bits set: lowest index wins, no error.
- WRITE to a full cache whose key hits: overwrite, err_full_out = 0.
- Reset asserted in any state: immediate return to IDLE. All strobes, idx_out, done_out and counters go to 0 without waiting for a clock edge. The in-flight command is dropped and produces no done_out.

## Test plan
- **Reset:** assert rst_n=0 mid-ACCESS of a WRITE. Required: write_out drops immediately, counters 0, no done_out, op_ready_out=1 after release.
- **READ hit, NUM_ENTRIES=16:** hit_in=16'h0020. Required: idx_out=16'h0020 with select_out in cycle +2; done_out and hit_out=1 in cycle +3; hit_cnt_out=1.
- **WRITE miss with allocation:** used_in=16'h00FF, hit_in=0. Required: write_out with idx_out=16'h0100; done_out with hit_out=0, err_full_out=0; miss_cnt_out=1.
- **WRITE when full:** used_in=16'hFFFF, hit_in=0. Required: no write_out, idx_out=0, err_full_out=1 with done_out. A second case with hit_in=16'h8000 must give write_out with idx_out=16'h8000 and err_full_out=0.
- **DELETE hit and miss, plus multi-hit:**
  - hit_in=16'h0006: delete_out with idx_out=16'h0002.
  - hit_in=0: no strobe, hit_out=0.
  - NOOP with valid: no done_out.
- **Saturation and handshake, STAT_W=2:**
  - Five READ hits. Required: hit_cnt_out sticks at 3.
  - Hold op_valid_in high throughout. Required: exactly one accept per 4 cycles, with op_ready_out low in LOOKUP/ACCESS/DONE.
